// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, LSB-first, 16x-free bit timing from baud_division.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          baud_division,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [2:0]           state;
    logic [15:0]          cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [15:0]          half_m1;
    logic [15:0]          full_m1;
    logic                 fall;
    logic                 full_hit;
`ifdef UART_RX_PARITY_EN
    logic                 par_acc;
    logic                 par_bad;
`endif

    assign half_m1  = (baud_division >> 1) - 16'd1;
    assign full_m1  = baud_division - 16'd1;
    assign fall     = rx_prev & ~rx_s;
    // >= rather than == so a mid-frame shrink of baud_division never lets cnt run away
    assign full_hit = (cnt >= full_m1);

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_cnt   <= 4'd0;
            shift     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!en) begin
                state   <= IDLE;
                cnt     <= 16'd0;
                bit_cnt <= 4'd0;
                shift   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall) begin
                            state <= START;
                            cnt   <= 16'd0;
                        end
                    end
                    START: begin
                        if (cnt >= half_m1) begin
                            cnt     <= 16'd0;
                            bit_cnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
                            par_acc <= 1'b0;
`endif
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (full_hit) begin
                            cnt   <= 16'd0;
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                            par_acc <= par_acc ^ rx_s;
`endif
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (full_hit) begin
                            cnt     <= 16'd0;
                            par_bad <= par_acc ^ rx_s;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (full_hit) begin
                            cnt   <= 16'd0;
                            state <= IDLE;
                            // a bad stop bit outranks a parity mismatch
                            if (!rx_s) begin
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
`endif
                            end else begin
                                data_out <= shift;
                                valid    <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
